// File: rtl/lsu_axil_bridge.sv
// lsu_axil_bridge
//
// Converts the core LSU's single-outstanding req/gnt/rvalid data interface
// into an AXI4-Lite master for the data RAM's AXI-Lite port. Only one core
// transaction is in flight at a time. A read runs AR then R. A write runs
// AW and W together, then B. Every transaction ends with a one-cycle
// data_rvalid_o pulse that carries the read data and the error flag.
//
// Ports
//   clk_i, rst_ni             clock; asynchronous active-low reset
//   data_req_i / data_gnt_o   core request / same-cycle grant (IDLE or RESP only)
//   data_we_i, data_be_i,
//   data_addr_i, data_wdata_i core request payload
//   data_rvalid_o             one-cycle completion pulse (reads and writes)
//   data_rdata_o              last captured read data (held between reads)
//   data_err_o                SLVERR/DECERR seen; qualified by data_rvalid_o
//   m_ar* / m_r*              AXI-Lite read address / read data channels
//   m_aw* / m_w* / m_b*       AXI-Lite write address / data / response channels
//   dbg_state_o               current FSM state, for checkers
//
// Handshake semantics (all AXI channels): a transfer happens on a rising
// clock edge where valid && ready. The source raises valid without looking
// at ready. Once valid is raised, it and its payload stay stable until that
// transfer. The sink may drive ready freely. On this master, rready and
// bready are high only in R and B.

module lsu_axil_bridge (
    input  logic        clk_i,
    input  logic        rst_ni,

    input  logic        data_req_i,
    output logic        data_gnt_o,
    input  logic        data_we_i,
    input  logic [3:0]  data_be_i,
    input  logic [31:0] data_addr_i,
    input  logic [31:0] data_wdata_i,
    output logic        data_rvalid_o,
    output logic [31:0] data_rdata_o,
    output logic        data_err_o,

    output logic        m_arvalid_o,
    input  logic        m_arready_i,
    output logic [31:0] m_araddr_o,
    output logic [2:0]  m_arprot_o,

    input  logic        m_rvalid_i,
    output logic        m_rready_o,
    input  logic [31:0] m_rdata_i,
    input  logic [1:0]  m_rresp_i,

    output logic        m_awvalid_o,
    input  logic        m_awready_i,
    output logic [31:0] m_awaddr_o,
    output logic [2:0]  m_awprot_o,

    output logic        m_wvalid_o,
    input  logic        m_wready_i,
    output logic [31:0] m_wdata_o,
    output logic [3:0]  m_wstrb_o,

    input  logic        m_bvalid_i,
    output logic        m_bready_o,
    input  logic [1:0]  m_bresp_i,

    output logic [2:0]  dbg_state_o
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        AR   = 3'd1,
        R    = 3'd2,
        AW_W = 3'd3,
        B    = 3'd4,
        RESP = 3'd5
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic        we_q, we_d;
    logic [3:0]  be_q, be_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;
    logic        aw_done_q, aw_done_d;
    logic        w_done_q, w_done_d;

    logic        gnt;
    logic        aw_hs, w_hs;

    // A new request is accepted in IDLE and also in RESP. Accepting in RESP
    // overlaps the completion cycle with the next grant, which gives one
    // transaction every 3 cycles against a zero-wait slave.
    assign gnt = data_req_i && (state_q == IDLE || state_q == RESP);

    // In AW_W, each valid drops on its own once its handshake is done.
    assign aw_hs = (state_q == AW_W) && !aw_done_q && m_awready_i;
    assign w_hs  = (state_q == AW_W) && !w_done_q  && m_wready_i;

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        we_d      = we_q;
        be_d      = be_q;
        wdata_d   = wdata_q;
        rdata_d   = rdata_q;
        err_d     = err_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;

        unique case (state_q)
            IDLE: ;
            AR: begin
                if (m_arready_i) state_d = R;
            end
            R: begin
                if (m_rvalid_i) begin
                    rdata_d = m_rdata_i;
                    err_d   = m_rresp_i[1];
                    state_d = RESP;
                end
            end
            AW_W: begin
                aw_done_d = aw_done_q | aw_hs;
                w_done_d  = w_done_q  | w_hs;
                if ((aw_done_q || aw_hs) && (w_done_q || w_hs)) state_d = B;
            end
            B: begin
                // A write leaves the read-data register untouched.
                if (m_bvalid_i) begin
                    err_d   = m_bresp_i[1];
                    state_d = RESP;
                end
            end
            RESP: state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // The grant overrides the RESP -> IDLE step.
        if (gnt) begin
            addr_d    = {data_addr_i[31:2], 2'b00};
            we_d      = data_we_i;
            be_d      = data_be_i;
            wdata_d   = data_wdata_i;
            aw_done_d = 1'b0;
            w_done_d  = 1'b0;
            state_d   = data_we_i ? AW_W : AR;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            we_q      <= 1'b0;
            be_q      <= '0;
            wdata_q   <= '0;
            rdata_q   <= '0;
            err_q     <= 1'b0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            we_q      <= we_d;
            be_q      <= be_d;
            wdata_q   <= wdata_d;
            rdata_q   <= rdata_d;
            err_q     <= err_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
        end
    end

    assign data_gnt_o    = gnt;
    assign data_rvalid_o = (state_q == RESP);
    assign data_rdata_o  = rdata_q;
    // The error flag only has meaning during the completion pulse.
    assign data_err_o    = (state_q == RESP) && err_q;

    assign m_arvalid_o = (state_q == AR);
    assign m_araddr_o  = addr_q;
    assign m_arprot_o  = 3'b000;
    assign m_rready_o  = (state_q == R);

    assign m_awvalid_o = (state_q == AW_W) && !aw_done_q;
    assign m_awaddr_o  = addr_q;
    assign m_awprot_o  = 3'b000;
    assign m_wvalid_o  = (state_q == AW_W) && !w_done_q;
    assign m_wdata_o   = wdata_q;
    assign m_wstrb_o   = be_q;
    assign m_bready_o  = (state_q == B);

    assign dbg_state_o = state_q;

    // we_q is held for visibility; the FSM path already encodes the direction.
    logic unused_we;
    assign unused_we = we_q;

endmodule

// File: tb/tb_lsu_axil_bridge.sv
// Directed testbench for lsu_axil_bridge. The bench drives the slave side
// of the AXI channels cycle by cycle. Inputs change on the falling edge, and
// outputs are checked 1 time unit after that.
module tb_lsu_axil_bridge;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        data_req_i;
    logic        data_gnt_o;
    logic        data_we_i;
    logic [3:0]  data_be_i;
    logic [31:0] data_addr_i;
    logic [31:0] data_wdata_i;
    logic        data_rvalid_o;
    logic [31:0] data_rdata_o;
    logic        data_err_o;
    logic        m_arvalid_o;
    logic        m_arready_i;
    logic [31:0] m_araddr_o;
    logic [2:0]  m_arprot_o;
    logic        m_rvalid_i;
    logic        m_rready_o;
    logic [31:0] m_rdata_i;
    logic [1:0]  m_rresp_i;
    logic        m_awvalid_o;
    logic        m_awready_i;
    logic [31:0] m_awaddr_o;
    logic [2:0]  m_awprot_o;
    logic        m_wvalid_o;
    logic        m_wready_i;
    logic [31:0] m_wdata_o;
    logic [3:0]  m_wstrb_o;
    logic        m_bvalid_i;
    logic        m_bready_o;
    logic [1:0]  m_bresp_i;
    logic [2:0]  dbg_state_o;

    int n_pass  = 0;
    int n_total = 0;

    // Clock: 10-unit period.
    always #5 clk_i = ~clk_i;

    lsu_axil_bridge dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .data_req_i   (data_req_i),
        .data_gnt_o   (data_gnt_o),
        .data_we_i    (data_we_i),
        .data_be_i    (data_be_i),
        .data_addr_i  (data_addr_i),
        .data_wdata_i (data_wdata_i),
        .data_rvalid_o(data_rvalid_o),
        .data_rdata_o (data_rdata_o),
        .data_err_o   (data_err_o),
        .m_arvalid_o  (m_arvalid_o),
        .m_arready_i  (m_arready_i),
        .m_araddr_o   (m_araddr_o),
        .m_arprot_o   (m_arprot_o),
        .m_rvalid_i   (m_rvalid_i),
        .m_rready_o   (m_rready_o),
        .m_rdata_i    (m_rdata_i),
        .m_rresp_i    (m_rresp_i),
        .m_awvalid_o  (m_awvalid_o),
        .m_awready_i  (m_awready_i),
        .m_awaddr_o   (m_awaddr_o),
        .m_awprot_o   (m_awprot_o),
        .m_wvalid_o   (m_wvalid_o),
        .m_wready_i   (m_wready_i),
        .m_wdata_o    (m_wdata_o),
        .m_wstrb_o    (m_wstrb_o),
        .m_bvalid_i   (m_bvalid_i),
        .m_bready_o   (m_bready_o),
        .m_bresp_i    (m_bresp_i),
        .dbg_state_o  (dbg_state_o)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    endtask

    // Advance one cycle, then wait until just after the falling edge.
    task automatic next_cycle();
        @(negedge clk_i);
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic slave_idle();
        m_arready_i = 1'b0;
        m_rvalid_i  = 1'b0;
        m_rdata_i   = '0;
        m_rresp_i   = 2'b00;
        m_awready_i = 1'b0;
        m_wready_i  = 1'b0;
        m_bvalid_i  = 1'b0;
        m_bresp_i   = 2'b00;
    endtask

    task automatic core_req(input logic we, input logic [31:0] addr,
                            input logic [3:0] be, input logic [31:0] wdata);
        data_req_i   = 1'b1;
        data_we_i    = we;
        data_addr_i  = addr;
        data_be_i    = be;
        data_wdata_i = wdata;
    endtask

    task automatic core_idle();
        data_req_i   = 1'b0;
        data_we_i    = 1'b0;
        data_addr_i  = '0;
        data_be_i    = '0;
        data_wdata_i = '0;
    endtask

    task automatic check_all_quiet(input string tag);
        check({tag, ".arvalid"}, 32'(m_arvalid_o), 32'd0);
        check({tag, ".rready"},  32'(m_rready_o),  32'd0);
        check({tag, ".awvalid"}, 32'(m_awvalid_o), 32'd0);
        check({tag, ".wvalid"},  32'(m_wvalid_o),  32'd0);
        check({tag, ".bready"},  32'(m_bready_o),  32'd0);
        check({tag, ".rvalid"},  32'(data_rvalid_o), 32'd0);
    endtask

    initial begin
        rst_ni = 1'b0;
        core_idle();
        slave_idle();

        // ---------------- Reset values ----------------
        #2;
        check_all_quiet("rst");
        check("rst.gnt",   32'(data_gnt_o), 32'd0);
        check("rst.err",   32'(data_err_o), 32'd0);
        check("rst.rdata", data_rdata_o, 32'h0);
        check("rst.araddr", m_araddr_o, 32'h0);
        check("rst.awaddr", m_awaddr_o, 32'h0);
        check("rst.wdata", m_wdata_o, 32'h0);
        check("rst.wstrb", 32'(m_wstrb_o), 32'h0);
        check("rst.prot",  32'({m_arprot_o, m_awprot_o}), 32'h0);
        check("rst.state", 32'(dbg_state_o), 32'd0);
        next_cycle();
        next_cycle();
        rst_ni = 1'b1;
        next_cycle();

        // ---------------- Read 0x10, zero-wait ----------------
        core_req(1'b0, 32'h0000_0010, 4'hF, 32'h0);            // cycle 0
        settle();
        check("rd0.gnt", 32'(data_gnt_o), 32'd1);
        next_cycle();                                          // cycle 1
        core_idle();
        m_arready_i = 1'b1;
        settle();
        check("rd0.arvalid", 32'(m_arvalid_o), 32'd1);
        check("rd0.araddr", m_araddr_o, 32'h0000_0010);
        check("rd0.rvalid_early", 32'(data_rvalid_o), 32'd0);
        next_cycle();                                          // cycle 2
        slave_idle();
        m_rvalid_i = 1'b1;
        m_rdata_i  = 32'hDEAD_BEEF;
        settle();
        check("rd0.rready", 32'(m_rready_o), 32'd1);
        check("rd0.arvalid_drop", 32'(m_arvalid_o), 32'd0);
        next_cycle();                                          // cycle 3
        slave_idle();
        settle();
        check("rd0.rvalid", 32'(data_rvalid_o), 32'd1);
        check("rd0.rdata", data_rdata_o, 32'hDEAD_BEEF);
        check("rd0.err", 32'(data_err_o), 32'd0);
        next_cycle();
        settle();
        check("rd0.rvalid_once", 32'(data_rvalid_o), 32'd0);
        check("rd0.rdata_hold", data_rdata_o, 32'hDEAD_BEEF);

        // ---------------- Write 0x24, awready stalled 3 cycles ----------------
        next_cycle();
        core_req(1'b1, 32'h0000_0024, 4'b0110, 32'h1234_5678);  // cycle 0
        settle();
        check("wr0.gnt", 32'(data_gnt_o), 32'd1);
        next_cycle();                                          // cycle 1
        core_idle();
        m_wready_i = 1'b1;
        settle();
        check("wr0.awvalid1", 32'(m_awvalid_o), 32'd1);
        check("wr0.wvalid1", 32'(m_wvalid_o), 32'd1);
        check("wr0.awaddr1", m_awaddr_o, 32'h0000_0024);
        check("wr0.wdata", m_wdata_o, 32'h1234_5678);
        check("wr0.wstrb", 32'(m_wstrb_o), 32'h6);
        for (int c = 2; c <= 3; c++) begin                     // cycles 2,3
            next_cycle();
            settle();
            check($sformatf("wr0.wvalid_drop%0d", c), 32'(m_wvalid_o), 32'd0);
            check($sformatf("wr0.awvalid%0d", c), 32'(m_awvalid_o), 32'd1);
            check($sformatf("wr0.awaddr%0d", c), m_awaddr_o, 32'h0000_0024);
            check($sformatf("wr0.state%0d", c), 32'(dbg_state_o), 32'd3);
        end
        next_cycle();                                          // cycle 4
        m_awready_i = 1'b1;
        settle();
        check("wr0.awvalid4", 32'(m_awvalid_o), 32'd1);
        check("wr0.no_bready", 32'(m_bready_o), 32'd0);
        next_cycle();                                          // cycle 5
        slave_idle();
        m_bvalid_i = 1'b1;
        settle();
        check("wr0.bready", 32'(m_bready_o), 32'd1);
        check("wr0.awvalid_drop", 32'(m_awvalid_o), 32'd0);
        check("wr0.rvalid_early", 32'(data_rvalid_o), 32'd0);
        next_cycle();                                          // cycle 6
        slave_idle();
        settle();
        check("wr0.rvalid", 32'(data_rvalid_o), 32'd1);
        check("wr0.err", 32'(data_err_o), 32'd0);
        check("wr0.rdata_kept", data_rdata_o, 32'hDEAD_BEEF);
        next_cycle();
        settle();
        check("wr0.rvalid_once", 32'(data_rvalid_o), 32'd0);

        // ---------------- Read with SLVERR ----------------
        core_req(1'b0, 32'h0000_0008, 4'hF, 32'h0);
        next_cycle();
        core_idle();
        m_arready_i = 1'b1;
        next_cycle();
        slave_idle();
        m_rvalid_i = 1'b1;
        m_rdata_i  = 32'hCAFE_0001;
        m_rresp_i  = 2'b10;
        next_cycle();
        slave_idle();
        settle();
        check("rderr.rvalid", 32'(data_rvalid_o), 32'd1);
        check("rderr.err", 32'(data_err_o), 32'd1);
        check("rderr.rdata", data_rdata_o, 32'hCAFE_0001);
        next_cycle();
        settle();
        check("rderr.err_clear", 32'(data_err_o), 32'd0);

        // ---------------- Write with DECERR ----------------
        core_req(1'b1, 32'h0000_0004, 4'hF, 32'h0BAD_F00D);
        next_cycle();
        core_idle();
        m_awready_i = 1'b1;
        m_wready_i  = 1'b1;
        next_cycle();
        slave_idle();
        m_bvalid_i = 1'b1;
        m_bresp_i  = 2'b11;
        next_cycle();
        slave_idle();
        settle();
        check("wrerr.rvalid", 32'(data_rvalid_o), 32'd1);
        check("wrerr.err", 32'(data_err_o), 32'd1);
        check("wrerr.rdata_kept", data_rdata_o, 32'hCAFE_0001);
        next_cycle();

        // ---------------- Back-to-back alternating read/write ----------------
        // Request held high. Grants land every 3 cycles, and each RESP cycle
        // also carries the grant of the next transaction.
        m_arready_i = 1'b1;
        m_awready_i = 1'b1;
        m_wready_i  = 1'b1;
        for (int i = 0; i < 4; i++) begin
            core_req(i[0], 32'h0000_0040 + 32'(i * 4), 4'hF, 32'h5000_0000 + 32'(i));
            settle();
            check($sformatf("b2b%0d.gnt", i), 32'(data_gnt_o), 32'd1);
            if (i == 0) begin
                check("b2b0.no_rvalid", 32'(data_rvalid_o), 32'd0);
            end else begin
                check($sformatf("b2b%0d.prev_rvalid", i), 32'(data_rvalid_o), 32'd1);
                check($sformatf("b2b%0d.prev_rdata", i), data_rdata_o,
                      (i == 1 || i == 2) ? 32'hA000_0000 : 32'hA000_0002);
            end
            next_cycle();
            m_rvalid_i = 1'b0;
            m_bvalid_i = 1'b0;
            settle();
            check($sformatf("b2b%0d.busy_gnt1", i), 32'(data_gnt_o), 32'd0);
            check($sformatf("b2b%0d.ar", i), 32'(m_arvalid_o), i[0] ? 32'd0 : 32'd1);
            check($sformatf("b2b%0d.aw", i), 32'(m_awvalid_o), i[0] ? 32'd1 : 32'd0);
            next_cycle();
            m_rvalid_i = 1'b1;
            m_rdata_i  = 32'hA000_0000 + 32'(i);
            m_bvalid_i = 1'b1;
            settle();
            check($sformatf("b2b%0d.busy_gnt2", i), 32'(data_gnt_o), 32'd0);
            next_cycle();
            m_rvalid_i = 1'b0;
            m_bvalid_i = 1'b0;
        end
        core_idle();
        settle();
        check("b2b.last_rvalid", 32'(data_rvalid_o), 32'd1);
        check("b2b.last_rdata", data_rdata_o, 32'hA000_0002);
        slave_idle();
        next_cycle();

        // ---------------- Unaligned address ----------------
        core_req(1'b0, 32'h0000_0013, 4'hF, 32'h0);
        next_cycle();
        core_idle();
        m_arready_i = 1'b1;
        settle();
        check("unal.araddr", m_araddr_o, 32'h0000_0010);
        next_cycle();
        slave_idle();
        m_rvalid_i = 1'b1;
        m_rdata_i  = 32'h1313_1313;
        next_cycle();
        slave_idle();
        settle();
        check("unal.rdata", data_rdata_o, 32'h1313_1313);
        next_cycle();

        // ---------------- Reset while in R ----------------
        core_req(1'b0, 32'h0000_0020, 4'hF, 32'h0);
        next_cycle();
        core_idle();
        m_arready_i = 1'b1;
        next_cycle();
        slave_idle();
        settle();
        check("rstR.in_R", 32'(dbg_state_o), 32'd2);
        rst_ni = 1'b0;
        settle();
        check_all_quiet("rstR");
        check("rstR.state", 32'(dbg_state_o), 32'd0);
        check("rstR.rdata", data_rdata_o, 32'h0);
        next_cycle();
        settle();
        check("rstR.no_rvalid", 32'(data_rvalid_o), 32'd0);
        rst_ni = 1'b1;
        next_cycle();
        core_req(1'b0, 32'h0000_0030, 4'hF, 32'h0);
        settle();
        check("rstR.fresh_gnt", 32'(data_gnt_o), 32'd1);
        next_cycle();
        core_idle();
        m_arready_i = 1'b1;
        settle();
        check("rstR.fresh_araddr", m_araddr_o, 32'h0000_0030);
        next_cycle();
        slave_idle();
        m_rvalid_i = 1'b1;
        m_rdata_i  = 32'h5A5A_5A5A;
        next_cycle();
        slave_idle();
        settle();
        check("rstR.fresh_rvalid", 32'(data_rvalid_o), 32'd1);
        check("rstR.fresh_rdata", data_rdata_o, 32'h5A5A_5A5A);
        check("rstR.fresh_err", 32'(data_err_o), 32'd0);
        next_cycle();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/lsu_axil_bridge.md
# lsu_axil_bridge

Upstream bridge converting the core's single-outstanding req/gnt/rvalid data interface into an AXI4-Lite master that drives the AXI-Lite port (port A) of the dual-port data RAM. Accepts one core transaction at a time, issues the matching AR/R or AW/W/B sequence, and returns read data or write completion with an error flag. Sits between the core LSU and the RAM's AXI-Lite slave port.

## Interface
- AxProt, 3'b000, constant driven on m_arprot_o / m_awprot_o
- clk_i  in  1  clock
- rst_ni  in  1  reset, asynchronous, active-low
- data_req_i  in  1  core request
- data_gnt_o  out  1  request accepted this cycle
- data_we_i  in  1  1 = write, 0 = read
- data_be_i  in  4  byte enables
- data_addr_i  in  32  byte address
- data_wdata_i  in  32  write data
- data_rvalid_o  out  1  one-cycle completion pulse (read and write)
- data_rdata_o  out  32  read data, valid with data_rvalid_o
- data_err_o  out  1  response error, valid with data_rvalid_o
- m_arvalid_o / m_arready_i / m_araddr_o[31:0] / m_arprot_o[2:0]  AXI read address channel
- m_rvalid_i / m_rready_o / m_rdata_i[31:0] / m_rresp_i[1:0]  AXI read data channel
- m_awvalid_o / m_awready_i / m_awaddr_o[31:0] / m_awprot_o[2:0]  AXI write address channel
- m_wvalid_o / m_wready_i / m_wdata_o[31:0] / m_wstrb_o[3:0]  AXI write data channel
- m_bvalid_i / m_bready_o / m_bresp_i[1:0]  AXI write response channel

## Operation
- States: IDLE, AR, R, AW_W, B, RESP. Reset state IDLE.
- data_gnt_o = data_req_i when state is IDLE or RESP (combinational); 0 otherwise.
- On grant: register addr (as {addr[31:2],2'b00}), we, be, wdata; go to AR if read, AW_W if write.
- AR: m_arvalid_o = 1, m_araddr_o = registered addr. On arvalid && arready -> R.
- R: m_rready_o = 1. On rvalid && rready: capture rdata, err = rresp[1] -> RESP.
- AW_W: m_awvalid_o and m_wvalid_o both raised on entry; each drops individually after its own handshake (flags aw_done, w_done). m_wstrb_o = registered be, m_wdata_o = registered wdata. When both done (including same cycle) -> B.
- B: m_bready_o = 1. On bvalid && bready: err = bresp[1], data_rdata_o unchanged -> RESP.
- RESP: data_rvalid_o = 1 for exactly this cycle; next state IDLE, or AR/AW_W if a new grant occurs this cycle.
- AXI rules: a valid, once raised, is held with stable addr/data until its handshake; valid never depends on ready. rready/bready asserted only in R/B.
- data_rdata_o holds last captured read data between responses; data_err_o valid only with data_rvalid_o.
- Any rresp/bresp of SLVERR (2'b10) or DECERR (2'b11) sets data_err_o; OKAY/EXOKAY clear it.

## Timing
- Reset values: all valid/ready outputs 0, data_gnt_o 0 combinationally (follows IDLE), data_rvalid_o 0, data_err_o 0, data_rdata_o 0, m_* addr/data/strb 0, flags cleared.
- Reset asserted mid-transaction: immediate return to IDLE, all valids dropped, no data_rvalid_o pulse; the outstanding transaction is abandoned.
- Read, zero-wait slave (arready = 1, rvalid one cycle after AR): grant cycle 0, AR handshake cycle 1, R handshake cycle 2, data_rvalid_o cycle 3.
- Write, zero-wait slave: grant cycle 0, AW+W handshake cycle 1, B handshake cycle 2, data_rvalid_o cycle 3.
- Back-to-back: new grant in the RESP cycle gives throughput of one transaction per 3 cycles with a zero-wait slave.
- Slave stalls extend the corresponding state indefinitely; no timeout.
- At most one outstanding transaction; data_req_i while busy is not granted.

## Test plan
- Read 0x0000_0010, arready=1, rvalid next cycle with rdata=0xDEAD_BEEF, rresp=00 -> m_araddr_o=0x10, data_rvalid_o in cycle 3 with rdata 0xDEADBEEF, err 0.
- Write 0x0000_0024, be=4'b0110, wdata=0x1234_5678; awready held 0 for 3 cycles, wready=1 -> wvalid drops after cycle 1, awvalid held stable 3 cycles, m_wstrb_o=0110, single data_rvalid_o after B, err 0.
- Read with rresp=2'b10 -> data_rvalid_o with data_err_o=1; write with bresp=2'b11 -> data_err_o=1.
- Continuous data_req_i alternating read/write, zero-wait slave -> grants every 3 cycles, one rvalid per grant, order preserved, no grant while busy.
- Unaligned address 0x0000_0013 -> m_araddr_o=0x0000_0010.
- rst_ni pulled low while in R with m_rvalid_i=0 -> all m_*valid/ready 0, no data_rvalid_o; after release a fresh read completes normally.
